// File: rtl/accel_move_scheduler_pkg.sv
// Shared types for the move scheduler: direction codes, FSM states and
// the pulse-vector decode used at the front end.
package accel_pkg;

    typedef enum logic [1:0] {
        DIR_PX = 2'b00,
        DIR_NX = 2'b01,
        DIR_PY = 2'b10,
        DIR_NY = 2'b11
    } dir_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_DONE,
        COOLDOWN
    } state_t;

    // Multi-hot vectors resolve to the lowest set bit.
    function automatic dir_t decode_pulse(input logic [3:0] pulses);
        dir_t dir;
        casez (pulses)
            4'b???1: dir = DIR_PX;
            4'b??10: dir = DIR_NX;
            4'b?100: dir = DIR_PY;
            4'b1000: dir = DIR_NY;
            default: dir = DIR_PX;
        endcase
        return dir;
    endfunction

endpackage

// File: rtl/accel_move_scheduler_if.sv
// Move command channel between the scheduler (master) and the maze
// position logic (slave).
interface accel_move_if;
    import accel_pkg::*;

    logic move_valid;
    dir_t move_dir;
    logic move_ready;
    logic move_done;
    logic move_hit_wall;

    modport master (
        output move_valid,
        output move_dir,
        input  move_ready,
        input  move_done,
        input  move_hit_wall
    );

    modport slave (
        input  move_valid,
        input  move_dir,
        output move_ready,
        output move_done,
        output move_hit_wall
    );

endinterface

// File: rtl/move_fifo.sv
// Two-bit wide synchronous FIFO with simultaneous push/pop, synchronous
// flush and an exported next-count for registered status downstream.
module move_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [1:0]               wdata,
    output logic [1:0]               rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic [$clog2(DEPTH):0]   count_next,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [1:0]    mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == ($clog2(DEPTH)+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_comb begin
        count_next = count;
        if (flush)
            count_next = '0;
        else if (do_push && !do_pop)
            count_next = count + 1'b1;
        else if (!do_push && do_pop)
            count_next = count - 1'b1;
    end

    // NOTE: all state in clocked blocks uses <= so every flop sees pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            count <= count_next;
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (do_push) wr_ptr <= wr_ptr + 1'b1;
                if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // NOTE: storage is not reset; count and pointers alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/accel_move_scheduler.sv
// Queues tilt/button move pulses and issues them one at a time over a
// valid/ready channel, waiting for completion and a cooldown between moves.
module accel_move_scheduler
    import accel_pkg::*;
#(
    parameter int FIFO_DEPTH      = 4,
    parameter int COOLDOWN_CYCLES = 1000000,
    parameter int DONE_TIMEOUT    = 255
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    input  logic [3:0]                   accel_pulses,
    input  logic [3:0]                   btn_pulses,
    accel_move_if.master                 move,
    output logic [7:0]                   wall_hits,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
    output logic                         busy,
    output logic                         overflow,
    output logic                         timeout
);

    localparam int CCW = (COOLDOWN_CYCLES > 1) ? $clog2(COOLDOWN_CYCLES) : 1;
    localparam int TCW = (DONE_TIMEOUT > 1) ? $clog2(DONE_TIMEOUT) : 1;
    localparam logic [CCW-1:0] COOL_LAST = CCW'(COOLDOWN_CYCLES - 1);
    localparam logic [TCW-1:0] WAIT_LAST = TCW'(DONE_TIMEOUT - 1);

    state_t                       state;
    logic [CCW-1:0]               cool_cnt;
    logic [TCW-1:0]               wait_cnt;
    logic [1:0]                   head_bits;
    logic [$clog2(FIFO_DEPTH):0]  count_next;
    logic btn_any, accel_any, pulse_any, conflict;
    logic push, pop, full, empty;
    logic start, done_evt, expire, finish, cool_end, idle_next;
    dir_t pulse_dir;

    assign btn_any   = |btn_pulses;
    assign accel_any = |accel_pulses;
    assign pulse_any = btn_any || accel_any;
    assign conflict  = btn_any && accel_any;
    assign pulse_dir = decode_pulse(btn_any ? btn_pulses : accel_pulses);

    assign pop  = (state == ISSUE) && move.move_valid && move.move_ready;
    assign push = enable && pulse_any && (!full || pop);

    // Entries being flushed by enable=0 are never started.
    assign start     = (state == IDLE) && !empty && enable;
    assign done_evt  = (state == WAIT_DONE) && move.move_done;
    assign expire    = (state == WAIT_DONE) && !move.move_done && (wait_cnt == WAIT_LAST);
    assign finish    = done_evt || expire;
    assign cool_end  = (state == COOLDOWN) && (cool_cnt == COOL_LAST);
    assign idle_next = ((state == IDLE) && !start) || cool_end ||
                       (finish && (COOLDOWN_CYCLES == 0));

    move_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .pop        (pop),
        .flush      (!enable),
        .wdata      (pulse_dir),
        .rdata      (head_bits),
        .count      (fifo_count),
        .count_next (count_next),
        .full       (full),
        .empty      (empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            move.move_valid <= 1'b0;
            move.move_dir   <= DIR_PX;
            cool_cnt        <= '0;
            wait_cnt        <= '0;
            wall_hits       <= '0;
            busy            <= 1'b0;
            overflow        <= 1'b0;
            timeout         <= 1'b0;
        end else begin
            if (conflict || (enable && pulse_any && full && !pop))
                overflow <= 1'b1;
            busy <= !idle_next || (count_next != '0);

            unique case (state)
                IDLE: begin
                    if (start) begin
                        state           <= ISSUE;
                        move.move_valid <= 1'b1;
                        move.move_dir   <= dir_t'(head_bits);
                    end
                end
                ISSUE: begin
                    if (pop) begin
                        state           <= WAIT_DONE;
                        move.move_valid <= 1'b0;
                        wait_cnt        <= '0;
                    end
                end
                WAIT_DONE: begin
                    wait_cnt <= wait_cnt + 1'b1;
                    if (finish) begin
                        if (done_evt && move.move_hit_wall && (wall_hits != 8'hFF))
                            wall_hits <= wall_hits + 8'd1;
                        if (expire)
                            timeout <= 1'b1;
                        cool_cnt <= '0;
                        state    <= (COOLDOWN_CYCLES == 0) ? IDLE : COOLDOWN;
                    end
                end
                COOLDOWN: begin
                    if (cool_end)
                        state <= IDLE;
                    else
                        cool_cnt <= cool_cnt + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/accel_move_scheduler.md
# accel_move_scheduler

Sequences tilt- and button-generated move requests into single, paced move commands for the maze position logic. Accepts one-cycle move pulses from the accelerometer threshold ticker and from debounced pushbuttons, buffers them in a small FIFO, and issues one move at a time over a valid/ready handshake. It waits for completion, then enforces a cooldown before the next move. Sits between the accel/button front end and the maze/position datapath.

## Interface
- FIFO_DEPTH, 4: move queue entries, power of 2, ≥2.
- COOLDOWN_CYCLES, 1000000: idle cycles after each completed move (10 ms @ 100 MHz); 0 allowed.
- DONE_TIMEOUT, 255: max cycles to wait for move_done after handshake, ≥1.
- clk  in  1  system clock, 100 MHz.
- reset  in  1  asynchronous, active-high; clears all state.
- enable  in  1  1 = accept new pulses; 0 = drop and flush queue.
- accel_pulses  in  4  one-cycle pulses: [0] +x, [1] -x, [2] +y, [3] -y.
- btn_pulses  in  4  same encoding, from debounced buttons.
- move_valid  out  1  move command pending.
- move_dir  out  2  00 +x, 01 -x, 10 +y, 11 -y; stable while move_valid.
- move_ready  in  1  maze logic accepts command.
- move_done  in  1  one-cycle pulse, accepted move finished.
- move_hit_wall  in  1  qualified by move_done; move was blocked.
- wall_hits  out  8  saturating count of blocked moves.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  queued entries.
- busy  out  1  state ≠ IDLE or fifo_count ≠ 0.
- overflow  out  1  sticky: a pulse was dropped because the queue was full or an arbitration conflict occurred.
- timeout  out  1  sticky: DONE_TIMEOUT expired.

## Operation
- Reset values: all outputs 0, FIFO empty, state IDLE, counters 0.
- Pulse decode: a multi-hot vector takes the lowest set bit. One push per cycle. If both sources pulse in the same cycle, the button wins, the accel pulse is dropped, and overflow is set.
- Push rule: push when enable=1 and (FIFO not full or pop in same cycle). Otherwise drop the pulse; if the FIFO was full, set overflow.
- enable=0: flush the FIFO at the next edge. An in-flight command (ISSUE/WAIT_DONE/COOLDOWN) still completes.
- FSM:
  - IDLE → ISSUE when the FIFO is non-empty. move_dir is loaded from the FIFO head and move_valid is set.
  - ISSUE: hold move_valid and move_dir. On move_valid && move_ready: pop, move_valid ← 0, go to WAIT_DONE, clear the timeout counter.
  - WAIT_DONE: on move_done, if move_hit_wall then wall_hits += 1 (saturating at 255). Then go to COOLDOWN, or to IDLE if COOLDOWN_CYCLES=0. If no move_done arrives within DONE_TIMEOUT cycles, set timeout and go to COOLDOWN the same way.
  - COOLDOWN: count COOLDOWN_CYCLES cycles, then go to IDLE. Pulses are still queued during cooldown.
- move_done outside WAIT_DONE is ignored.
- overflow, timeout, and wall_hits clear only on reset.

## Timing
- All outputs are registered.
- Pulse sampled at edge N with FIFO empty and IDLE: fifo_count=1 after N; move_valid=1 after N+1.
- Handshake at edge M: move_valid=0 and fifo_count decrements after M.
- move_done at edge D: wall_hits updates after D; state is COOLDOWN after D.
- IDLE is reached after D+COOLDOWN_CYCLES. The next move_valid is asserted one edge later if the queue is non-empty.
- Timeout: if no done by edge M+DONE_TIMEOUT, timeout=1 after that edge.
- Push and pop at the same edge while full: count unchanged, no overflow.
- Asynchronous reset mid-transaction: move_valid drops immediately and the queue is lost.

## Structure
- Shared package accel_pkg holds:
  - direction encodings (DIR_PX=2'b00, DIR_NX, DIR_PY, DIR_NY);
  - FSM state enum (IDLE, ISSUE, WAIT_DONE, COOLDOWN);
  - a pulse-to-direction decode function.
- One sub-module, move_fifo: synchronous FIFO with width 2 and depth FIFO_DEPTH, simultaneous push/pop, count output, asynchronous reset.

## Test plan
Run with FIFO_DEPTH=4, COOLDOWN_CYCLES=4, DONE_TIMEOUT=8.
- accel_pulses=4'b0001 for 1 cycle, move_ready=1 → move_valid high 2 edges later with move_dir=00. After done, busy falls 4 cycles later.
- btn_pulses=4'b1000 and accel_pulses=4'b0001 in the same cycle → one command, move_dir=11; overflow=1; fifo_count peaks at 1.
- 6 accel pulses on consecutive cycles, move_ready=0 → fifo_count=4 with 1 entry in ISSUE head; overflow=1; directions issued in order.
- Handshake then no move_done → timeout=1 exactly 8 cycles after the handshake; next queued move issues after cooldown.
- 300 moves, each done with move_hit_wall=1 → wall_hits=255 (saturates, no wrap).
- Reset asserted in WAIT_DONE with 3 entries queued → all outputs 0 immediately; no move_valid afterwards without new pulses.
